// File: rtl/jacobian_sequencer_if.sv
// Trig request/acknowledge bus between the Jacobian
// sequencer and the shared trig unit.
interface jacobian_sequencer_if #(
  parameter int ANGLE_W = 16,
  parameter int TRIG_W  = 16
);
  logic                     trig_req;
  logic [ANGLE_W-1:0]       trig_angle;
  logic                     trig_ack;
  logic signed [TRIG_W-1:0] trig_sin;
  logic signed [TRIG_W-1:0] trig_cos;

  modport master (
    output trig_req, trig_angle,
    input  trig_ack, trig_sin, trig_cos
  );

  modport slave (
    input  trig_req, trig_angle,
    output trig_ack, trig_sin, trig_cos
  );
endinterface

// File: rtl/jacobian_sequencer.sv
// Two-link SCARA Jacobian sequencer: fetches sin/cos of
// th1 and th1+th2 from a shared trig unit, forms 4 terms.
module jacobian_sequencer #(
  parameter int ANGLE_W = 16,
  parameter int LEN_W   = 14,
  parameter int TRIG_W  = 16,
  parameter int OUT_W   = 15,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ANGLE_W-1:0]      theta1,
  input  logic [ANGLE_W-1:0]      theta2,
  input  logic [LEN_W-1:0]        l1,
  input  logic [LEN_W-1:0]        l2,
  jacobian_sequencer_if.master    trig,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic signed [OUT_W-1:0] dx_dth1,
  output logic signed [OUT_W-1:0] dx_dth2,
  output logic signed [OUT_W-1:0] dy_dth1,
  output logic signed [OUT_W-1:0] dy_dth2
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = LEN_W + 1 + TRIG_W;
  localparam int SW = OUT_W + 5;
  localparam logic signed [SW-1:0] MAXV =
    SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_A, S_GAP, S_REQ_B, S_CALC, S_OUT
  } state_t;

  state_t state, state_n;

  logic [ANGLE_W-1:0]       th1_q, th2_q;
  logic [LEN_W-1:0]         l1_q, l2_q;
  logic signed [TRIG_W-1:0] s1_q, c1_q, s12_q, c12_q;
  logic [CW-1:0]            wcnt;
  logic                     in_req, tmo;

  logic signed [PW-1:0] m1s, m2s, m1c, m2c;
  logic signed [SW-1:0] p1s, p2s, p1c, p2c;
  logic signed [SW-1:0] dx1, dy1;

  function automatic logic signed [OUT_W-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > MAXV)      sat = MAXV[OUT_W-1:0];
    else if (v < MINV) sat = MINV[OUT_W-1:0];
    else               sat = v[OUT_W-1:0];
  endfunction

  assign in_req = (state == S_REQ_A) || (state == S_REQ_B);
  // a late ack on the last allowed cycle still wins
  assign tmo = in_req && !trig.trig_ack &&
               (wcnt == CW'(TIMEOUT - 1));

  assign m1s = $signed({1'b0, l1_q}) * s1_q;
  assign m2s = $signed({1'b0, l2_q}) * s12_q;
  assign m1c = $signed({1'b0, l1_q}) * c1_q;
  assign m2c = $signed({1'b0, l2_q}) * c12_q;
  assign p1s = SW'(m1s >>> (TRIG_W - 2));
  assign p2s = SW'(m2s >>> (TRIG_W - 2));
  assign p1c = SW'(m1c >>> (TRIG_W - 2));
  assign p2c = SW'(m2c >>> (TRIG_W - 2));
  assign dx1 = -p1s - p2s;
  assign dy1 = p1c + p2c;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_REQ_A;
      S_REQ_A: begin
        if (trig.trig_ack) state_n = S_GAP;
        else if (tmo)      state_n = S_IDLE;
      end
      S_GAP:   state_n = S_REQ_B;
      S_REQ_B: begin
        if (trig.trig_ack) state_n = S_CALC;
        else if (tmo)      state_n = S_IDLE;
      end
      S_CALC:  state_n = S_OUT;
      S_OUT:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    trig.trig_req   = in_req;
    trig.trig_angle = '0;
    if (state == S_REQ_A)
      trig.trig_angle = th1_q;
    else if (state == S_REQ_B)
      trig.trig_angle = th1_q + th2_q;
    done = (state == S_OUT);
    busy = (state != S_IDLE) || err;
  end

  // snapshot, trig results, wait counter and result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      th1_q   <= '0;
      th2_q   <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      s1_q    <= '0;
      c1_q    <= '0;
      s12_q   <= '0;
      c12_q   <= '0;
      wcnt    <= '0;
      err     <= 1'b0;
      dx_dth1 <= '0;
      dx_dth2 <= '0;
      dy_dth1 <= '0;
      dy_dth2 <= '0;
    end else begin
      err <= tmo;
      if (state == S_IDLE && start) begin
        th1_q <= theta1;
        th2_q <= theta2;
        l1_q  <= l1;
        l2_q  <= l2;
      end
      if (state == S_REQ_A && trig.trig_ack) begin
        s1_q <= trig.trig_sin;
        c1_q <= trig.trig_cos;
      end
      if (state == S_REQ_B && trig.trig_ack) begin
        s12_q <= trig.trig_sin;
        c12_q <= trig.trig_cos;
      end
      if (!in_req)
        wcnt <= '0;
      else if (!trig.trig_ack)
        wcnt <= wcnt + CW'(1);
      if (state == S_CALC) begin
        dx_dth1 <= sat(dx1);
        dx_dth2 <= sat(-p2s);
        dy_dth1 <= sat(dy1);
        dy_dth2 <= sat(p2c);
      end
    end
  end

endmodule

// File: tb/tb_jacobian_sequencer.sv
// Scoreboard bench for jacobian_sequencer with a
// configurable wait/never-ack trig unit model.
module tb_jacobian_sequencer;

  typedef struct packed {
    logic signed [14:0] dx1;
    logic signed [14:0] dx2;
    logic signed [14:0] dy1;
    logic signed [14:0] dy2;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start;
  logic [15:0] theta1, theta2;
  logic [13:0] l1, l2;
  logic busy, done, err;
  logic signed [14:0] dx_dth1, dx_dth2, dy_dth1, dy_dth2;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  exp_t sb[$];
  exp_t last_exp = '0;
  exp_t mon_e;

  logic [15:0] m_ang_a = 16'h0;
  logic signed [15:0] m_sa = 0, m_ca = 0;
  logic signed [15:0] m_sb = 0, m_cb = 0;
  int m_wait = 0;
  logic m_never = 1'b0;
  int m_cnt = 0;

  jacobian_sequencer_if #(.ANGLE_W(16), .TRIG_W(16)) tif ();

  jacobian_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .theta1(theta1), .theta2(theta2),
    .l1(l1), .l2(l2), .trig(tif),
    .busy(busy), .done(done), .err(err),
    .dx_dth1(dx_dth1), .dx_dth2(dx_dth2),
    .dy_dth1(dy_dth1), .dy_dth2(dy_dth2)
  );

  always #5 clk = ~clk;

  assign tif.trig_ack = tif.trig_req && !m_never &&
                        (m_cnt >= m_wait);
  assign tif.trig_sin = (tif.trig_angle == m_ang_a) ? m_sa : m_sb;
  assign tif.trig_cos = (tif.trig_angle == m_ang_a) ? m_ca : m_cb;

  always @(posedge clk)
    m_cnt <= (!tif.trig_req || tif.trig_ack) ? 0 : m_cnt + 1;

  // scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done got done=1 want none pending");
      end else begin
        mon_e = sb.pop_front();
        if ({dx_dth1, dx_dth2, dy_dth1, dy_dth2} !== mon_e) begin
          failures++;
          $display("FAIL sb_result got %0d %0d %0d %0d want %0d %0d %0d %0d",
                   dx_dth1, dx_dth2, dy_dth1, dy_dth2,
                   mon_e.dx1, mon_e.dx2, mon_e.dy1, mon_e.dy2);
        end
        last_exp = mon_e;
      end
    end
  end

  task automatic set_model(input logic [15:0] ang_a,
                           input int sa, input int ca,
                           input int sbv, input int cbv,
                           input int w);
    m_ang_a = ang_a;
    m_sa = 16'(sa);
    m_ca = 16'(ca);
    m_sb = 16'(sbv);
    m_cb = 16'(cbv);
    m_wait = w;
    m_never = 1'b0;
  endtask

  task automatic run_eval(input logic [15:0] t1, input logic [15:0] t2,
                          input logic [13:0] a, input logic [13:0] b,
                          input exp_t e, input int lat,
                          input string nm);
    int n;
    @(posedge clk); #1;
    theta1 = t1; theta2 = t2; l1 = a; l2 = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1 || n != lat) begin
      failures++;
      $display("FAIL %s_latency got cycle=%0d done=%b want cycle=%0d",
               nm, n, done, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0;
    theta1 = '0; theta2 = '0; l1 = '0; l2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tif.trig_req !== 1'b0 || tif.trig_angle !== 16'h0) begin
      failures++;
      $display("FAIL reset_trig got req=%b angle=%h want 0 0000",
               tif.trig_req, tif.trig_angle);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got busy/done/err=%b%b%b want 000",
               busy, done, err);
    end
    checks++;
    if ({dx_dth1, dx_dth2, dy_dth1, dy_dth2} !== 60'h0) begin
      failures++;
      $display("FAIL reset_terms got %0d %0d %0d %0d want 0 0 0 0",
               dx_dth1, dx_dth2, dy_dth1, dy_dth2);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    set_model(16'h0000, 0, 16384, 0, 16384, 0);
    run_eval(16'h0, 16'h0, 14'd8000, 14'd6000,
             '{15'sd0, 15'sd0, 15'sd14000, 15'sd6000}, 5, "zero");
  endtask

  task automatic test_quarter;
    set_model(16'h4000, 16384, 0, 16384, 0, 3);
    run_eval(16'h4000, 16'h0, 14'd8000, 14'd6000,
             '{-15'sd14000, -15'sd6000, 15'sd0, 15'sd0}, 11, "quarter");
  endtask

  task automatic test_saturation;
    set_model(16'h0000, 0, 16384, 0, 16384, 0);
    run_eval(16'h0, 16'h0, 14'd16383, 14'd16383,
             '{15'sd0, 15'sd0, 15'sd16383, 15'sd16383}, 5, "sat_cos");
    set_model(16'h0000, -16384, 0, -16384, 0, 1);
    run_eval(16'h0, 16'h0, 14'd16383, 14'd16383,
             '{15'sd16383, 15'sd16383, 15'sd0, 15'sd0}, 7, "sat_sin");
  endtask

  task automatic test_mixed;
    set_model(16'h1000, 8192, -8192, -4096, 12288, 0);
    run_eval(16'h1000, 16'h2000, 14'd10000, 14'd4000,
             '{-15'sd4000, 15'sd1000, -15'sd2000, 15'sd3000}, 5, "mixed");
    set_model(16'h0000, -1, 1, -1, 1, 0);
    run_eval(16'h0, 16'h0, 14'd3, 14'd5,
             '{15'sd2, 15'sd1, 15'sd0, 15'sd0}, 5, "floor");
  endtask

  task automatic test_wrap;
    set_model(16'hC000, 0, 16384, 0, 16384, 0);
    @(posedge clk); #1;
    theta1 = 16'hC000; theta2 = 16'h8000;
    l1 = 14'd1000; l2 = 14'd2000;
    start = 1'b1;
    sb.push_back('{15'sd0, 15'sd0, 15'sd3000, 15'sd2000});
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (tif.trig_req !== 1'b1 || tif.trig_angle !== 16'hC000) begin
      failures++;
      $display("FAIL wrap_req_a got req=%b angle=%h want 1 c000",
               tif.trig_req, tif.trig_angle);
    end
    @(posedge clk); #1;
    checks++;
    if (tif.trig_req !== 1'b0) begin
      failures++;
      $display("FAIL wrap_gap got req=%b want 0", tif.trig_req);
    end
    @(posedge clk); #1;
    checks++;
    if (tif.trig_req !== 1'b1 || tif.trig_angle !== 16'h4000) begin
      failures++;
      $display("FAIL wrap_req_b got req=%b angle=%h want 1 4000",
               tif.trig_req, tif.trig_angle);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout;
    int n;
    int d0;
    d0 = done_cnt;
    m_never = 1'b1;
    @(posedge clk); #1;
    theta1 = 16'h1234; theta2 = 16'h0100;
    l1 = 14'd500; l2 = 14'd700;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (err !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (err !== 1'b1 || n != 256) begin
      failures++;
      $display("FAIL timeout_err got cycle=%0d err=%b want cycle=256 err=1",
               n, err);
    end
    checks++;
    if (tif.trig_req !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_req_busy got req=%b busy=%b want 0 1",
               tif.trig_req, busy);
    end
    checks++;
    if ({dx_dth1, dx_dth2, dy_dth1, dy_dth2} !== last_exp) begin
      failures++;
      $display("FAIL timeout_hold got %0d %0d %0d %0d want %0d %0d %0d %0d",
               dx_dth1, dx_dth2, dy_dth1, dy_dth2,
               last_exp.dx1, last_exp.dx2, last_exp.dy1, last_exp.dy2);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL timeout_after got err=%b busy=%b dones=%0d want 0 0 %0d",
               err, busy, done_cnt, d0);
    end
    set_model(16'h0000, 0, 16384, 0, 16384, 0);
    run_eval(16'h0, 16'h0, 14'd8000, 14'd6000,
             '{15'sd0, 15'sd0, 15'sd14000, 15'sd6000}, 5, "post_timeout");
  endtask

  task automatic test_back_to_back;
    int n, d1, d2;
    set_model(16'h4000, 16384, 0, 16384, 0, 0);
    @(posedge clk); #1;
    theta1 = 16'h4000; theta2 = 16'h0;
    l1 = 14'd8000; l2 = 14'd6000;
    start = 1'b1;
    sb.push_back('{-15'sd14000, -15'sd6000, 15'sd0, 15'sd0});
    sb.push_back('{-15'sd14000, -15'sd6000, 15'sd0, 15'sd0});
    @(posedge clk); #1;
    n = 1; d1 = 0; d2 = 0;
    while (n <= 20) begin
      if (done === 1'b1) begin
        if (d1 == 0) d1 = n;
        else if (d2 == 0) d2 = n;
      end
      if (n == 7) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (d1 != 5 || d2 != 11) begin
      failures++;
      $display("FAIL b2b_spacing got done at %0d,%0d want 5,11", d1, d2);
    end
  endtask

  task automatic test_ignored_start;
    int n, d0, first;
    d0 = done_cnt;
    set_model(16'h0000, 0, 16384, 0, 16384, 0);
    @(posedge clk); #1;
    theta1 = 16'h0; theta2 = 16'h0;
    l1 = 14'd8000; l2 = 14'd6000;
    start = 1'b1;
    sb.push_back('{15'sd0, 15'sd0, 15'sd14000, 15'sd6000});
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; first = 0;
    while (n <= 20) begin
      start = (n == 2 || n == 3);
      if (n == 3) begin
        theta1 = 16'h4000; l1 = 14'd100;
      end
      if (done === 1'b1 && first == 0) first = n;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (done_cnt - d0 != 1 || first != 5) begin
      failures++;
      $display("FAIL ignored_start got dones=%0d first=%0d want 1 5",
               done_cnt - d0, first);
    end
  endtask

  task automatic test_reset_mid;
    int n, d0;
    d0 = done_cnt;
    set_model(16'h0010, 0, 16384, 0, 16384, 3);
    @(posedge clk); #1;
    theta1 = 16'h0010; theta2 = 16'h0020;
    l1 = 14'd900; l2 = 14'd800;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!(tif.trig_req === 1'b1 && tif.trig_angle === 16'h0030) &&
           n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (tif.trig_angle !== 16'h0030) begin
      failures++;
      $display("FAIL mid_reach_req_b got angle=%h want 0030",
               tif.trig_angle);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({tif.trig_req, busy, done, err} !== 4'b0000 ||
        tif.trig_angle !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset_ctrl got req=%b busy=%b done=%b err=%b angle=%h want 0",
               tif.trig_req, busy, done, err, tif.trig_angle);
    end
    checks++;
    if ({dx_dth1, dx_dth2, dy_dth1, dy_dth2} !== 60'h0) begin
      failures++;
      $display("FAIL mid_reset_terms got %0d %0d %0d %0d want 0 0 0 0",
               dx_dth1, dx_dth2, dy_dth1, dy_dth2);
    end
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_abandon got dones=%0d busy=%b want %0d 0",
               done_cnt - d0, busy, 0);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_quarter();
    test_saturation();
    test_mixed();
    test_wrap();
    test_timeout();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
